cpu_fetch_4004: RTL and testbench

//  4004-side bus master for the instruction-fetch path, directly upstream of rom_4004.

---
 rtl/cpu_fetch_4004.sv | 143 ++++++++++++++
 tb/tb_cpu_fetch_4004.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_fetch_4004.sv
// 4004 instruction-fetch bus master: derives clk1/clk2/sync from eclk, drives the PC nibbles and captures opcodes.
// Optional jump-load of the PC is enabled by defining JUMP_EN.
module cpu_fetch_4004 #(
  parameter int          QTR      = 2,
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic        eclk,
  input  logic        ereset,
  input  logic        run,
  input  logic [3:0]  db_rom,
  input  logic        jmp_valid,
  input  logic [11:0] jmp_addr,
  output logic        clk1,
  output logic        clk2,
  output logic        sync,
  output logic        cm_rom,
  output logic [3:0]  db,
  output logic [11:0] pc,
  output logic        instr_valid,
  output logic [7:0]  instr,
  output logic        busy
);

  localparam int QW = (QTR > 1) ? $clog2(QTR) : 1;
  localparam logic [QW-1:0] QLAST = QW'(QTR - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, nxt_state;
  logic [QW-1:0] qc, nxt_qc;
  logic [1:0]    q, nxt_q;
  logic [2:0]    s, nxt_s;
  logic [11:0]   nxt_pc;
  logic [3:0]    opr, opa;
  logic          last_qc, last_q, cyc_end, run_n, x1_start;

`ifdef JUMP_EN
  logic          jv, nxt_jv;
  logic [11:0]   ja, nxt_ja;
`else
  logic          unused_jmp;
  assign unused_jmp = ^{jmp_valid, jmp_addr};
`endif

  always_comb begin
    nxt_state = state;
    nxt_qc    = qc;
    nxt_q     = q;
    nxt_s     = s;
    nxt_pc    = pc;
`ifdef JUMP_EN
    nxt_jv    = jv;
    nxt_ja    = ja;
`endif
    last_qc   = (qc == QLAST);
    last_q    = last_qc && (q == 2'd3);
    cyc_end   = last_q && (s == 3'd7);
    if (state == IDLE) begin
      if (run) nxt_state = RUN;
    end else begin
      nxt_qc = last_qc ? '0 : qc + QW'(1);
      if (last_qc) nxt_q = q + 2'd1;
      if (last_q)  nxt_s = s + 3'd1;
`ifdef JUMP_EN
      // A request on the final eclk of X3 still lands at this boundary.
      if (jmp_valid) begin
        nxt_jv = 1'b1;
        nxt_ja = jmp_addr;
      end
`endif
      if (cyc_end) begin
`ifdef JUMP_EN
        nxt_pc = nxt_jv ? nxt_ja : pc + 12'd1;
        nxt_jv = 1'b0;
`else
        nxt_pc = pc + 12'd1;
`endif
        if (!run) nxt_state = IDLE;
      end
    end
    run_n    = (nxt_state == RUN);
    x1_start = run_n && (nxt_s == 3'd5) && (nxt_q == 2'd0) && (nxt_qc == '0);
  end

  // Outputs are decoded from the next position so they line up with the counters.
  always_ff @(posedge eclk) begin
    if (ereset) begin
      state       <= IDLE;
      qc          <= '0;
      q           <= 2'd0;
      s           <= 3'd0;
      pc          <= RESET_PC;
      clk1        <= 1'b0;
      clk2        <= 1'b0;
      sync        <= 1'b0;
      cm_rom      <= 1'b0;
      db          <= 4'h0;
      instr       <= 8'h00;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
`ifdef JUMP_EN
      jv          <= 1'b0;
`endif
    end else begin
      state       <= nxt_state;
      qc          <= nxt_qc;
      q           <= nxt_q;
      s           <= nxt_s;
      pc          <= nxt_pc;
      clk1        <= run_n && (nxt_q == 2'd0);
      clk2        <= run_n && (nxt_q == 2'd2);
      sync        <= run_n && (nxt_s == 3'd7);
      cm_rom      <= run_n && (nxt_s == 3'd2);
      busy        <= run_n;
      instr_valid <= x1_start;
      if (x1_start) instr <= {opr, opa};
      db <= 4'h0;
      if (run_n) begin
        case (nxt_s)
          3'd0:    db <= nxt_pc[3:0];
          3'd1:    db <= nxt_pc[7:4];
          3'd2:    db <= nxt_pc[11:8];
          default: db <= 4'h0;
        endcase
      end
`ifdef JUMP_EN
      jv          <= nxt_jv;
`endif
    end
  end

  // Opcode nibbles are sampled on the last eclk of clk2 in M1 and M2.
  always_ff @(posedge eclk) begin
    if (state == RUN && last_qc && q == 2'd2) begin
      if (s == 3'd3) opr <= db_rom;
      if (s == 3'd4) opa <= db_rom;
    end
`ifdef JUMP_EN
    ja <= nxt_ja;
`endif
  end

endmodule

// File: tb/tb_cpu_fetch_4004.sv
// Bench for cpu_fetch_4004: a ROM bus model answers fetches, a cycle-index reference model predicts every output.
module tb_cpu_fetch_4004;

  localparam int QTR = 2;
  localparam int P   = 4 * QTR;
  localparam int CYC = 32 * QTR;
  localparam logic [11:0] RST_PC = 12'h000;

  logic        eclk = 1'b0, ereset = 1'b1, run = 1'b0, jmp_valid = 1'b0, run_w = 1'b0;
  logic [11:0] jmp_addr = 12'h000;
  logic [3:0]  db_rom;
  logic        clk1, clk2, sync, cm_rom, instr_valid, busy;
  logic [3:0]  db;
  logic [11:0] pc;
  logic [7:0]  instr;
  logic        clk1_w, clk2_w, sync_w, cm_w, iv_w, busy_w;
  logic [3:0]  db_w;
  logic [11:0] pc_w;
  logic [7:0]  instr_w;

  int n_vec = 0, n_bad = 0, ecnt = 0, p_last = 0;
  logic [7:0] mem [4096];

  always #5 eclk = ~eclk;
  always @(posedge eclk) ecnt++;

  cpu_fetch_4004 #(.QTR(QTR), .RESET_PC(RST_PC)) dut (
    .eclk(eclk), .ereset(ereset), .run(run), .db_rom(db_rom), .jmp_valid(jmp_valid),
    .jmp_addr(jmp_addr), .clk1(clk1), .clk2(clk2), .sync(sync), .cm_rom(cm_rom), .db(db),
    .pc(pc), .instr_valid(instr_valid), .instr(instr), .busy(busy));

  cpu_fetch_4004 #(.QTR(1), .RESET_PC(12'hFFF)) dut_w (
    .eclk(eclk), .ereset(ereset), .run(run_w), .db_rom(4'hA), .jmp_valid(1'b0),
    .jmp_addr(12'h000), .clk1(clk1_w), .clk2(clk2_w), .sync(sync_w), .cm_rom(cm_w), .db(db_w),
    .pc(pc_w), .instr_valid(iv_w), .instr(instr_w), .busy(busy_w));

  // ROM bus model: counts subcycles on clk2 falling edges, realigns on sync, latches address nibbles
  int          rom_sub = 0;
  logic [11:0] rom_addr = 12'h000;
  logic        prev_clk2 = 1'b0;
  always @(negedge eclk) begin
    #1;
    if (ereset) begin
      rom_sub   = 0;
      prev_clk2 = 1'b0;
    end else begin
      if (clk2 && rom_sub < 3) rom_addr[4*rom_sub +: 4] = db;
      if (prev_clk2 && !clk2) rom_sub = sync ? 0 : rom_sub + 1;
      prev_clk2 = clk2;
    end
  end
  assign db_rom = (rom_sub == 3) ? mem[rom_addr][7:4] : (rom_sub == 4) ? mem[rom_addr][3:0] : 4'h0;

  // Reference model: position inside the instruction cycle as a plain eclk index
  logic        m_busy = 1'b0, m_jv = 1'b0;
  int          m_t = 0;
  logic [11:0] m_pc = RST_PC, m_ja = 12'h000;
  logic [7:0]  m_instr = 8'h00;
  always @(posedge eclk) begin
    if (ereset) begin
      m_busy = 1'b0; m_t = 0; m_pc = RST_PC; m_jv = 1'b0; m_instr = 8'h00;
    end else if (!m_busy) begin
      if (run) begin m_busy = 1'b1; m_t = 0; end
    end else begin
`ifdef JUMP_EN
      if (jmp_valid) begin m_jv = 1'b1; m_ja = jmp_addr; end
`endif
      if (m_t == CYC - 1) begin
        m_pc = m_jv ? m_ja : m_pc + 12'd1;
        m_jv = 1'b0; m_t = 0; m_busy = run;
      end else m_t++;
      if (m_busy && m_t == 5 * P) m_instr = mem[m_pc];
    end
  end

  int         e_s, e_q;
  logic [3:0] e_db;
  logic [29:0] exp_w, obs_w;
  always_comb begin
    e_s  = m_t / P;
    e_q  = (m_t / QTR) % 4;
    e_db = 4'h0;
    if (m_busy && e_s < 3) e_db = m_pc[4*e_s +: 4];
    exp_w = {m_busy && e_q == 0, m_busy && e_q == 2, m_busy && e_s == 7, m_busy && e_s == 2,
             e_db, m_busy, m_busy && m_t == 5 * P, m_pc, m_instr};
  end
  assign obs_w = {clk1, clk2, sync, cm_rom, db, busy, instr_valid, pc, instr};

  task automatic test_reset();
    repeat (2) @(negedge eclk);
    n_vec++;
    if (obs_w !== exp_w) begin n_bad++; $display("FAIL reset_model got %h want %h", obs_w, exp_w); end
    n_vec++;
    if ({clk1, clk2, sync, cm_rom, db, busy, instr_valid, instr} !== 16'h0 || pc !== RST_PC) begin
      n_bad++; $display("FAIL reset_zero got %h want 0 pc=%h", obs_w, RST_PC);
    end
    n_vec++;
    if (pc_w !== 12'hFFF || busy_w !== 1'b0) begin
      n_bad++; $display("FAIL reset_pc_w got pc=%h busy=%b want FFF 0", pc_w, busy_w);
    end
    ereset = 1'b0;
  endtask

  task automatic test_wrap();
    logic [11:0] wpc;
    int t, s;
    logic [3:0] edb;
    run_w = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge eclk);
      t = k % 32; s = t / 4; wpc = (k < 32) ? 12'hFFF : 12'h000;
      edb = (s < 3) ? wpc[4*s +: 4] : 4'h0;
      n_vec++;
      if ({clk1_w, clk2_w, sync_w, cm_w, db_w, busy_w, iv_w, pc_w} !==
          {t % 4 == 0, t % 4 == 2, s == 7, s == 2, edb, 1'b1, t == 20, wpc}) begin
        n_bad++;
        $display("FAIL wrap k=%0d got %b%b%b%b db=%h b=%b v=%b pc=%h want db=%h pc=%h", k, clk1_w, clk2_w,
                 sync_w, cm_w, db_w, busy_w, iv_w, pc_w, edb, wpc);
      end
      if (iv_w) begin
        n_vec++;
        if (instr_w !== 8'hAA) begin n_bad++; $display("FAIL wrap_instr got %h want AA", instr_w); end
      end
      if (k == 40) run_w = 1'b0;
    end
    @(negedge eclk);
    n_vec++;
    if (busy_w !== 1'b0 || pc_w !== 12'h001) begin
      n_bad++; $display("FAIL wrap_stop got busy=%b pc=%h want 0 001", busy_w, pc_w);
    end
  endtask

  task automatic test_fetch();
    int pulses = 0;
    run = 1'b1;
    for (int k = 0; k <= CYC + 3 * P; k++) begin
      @(negedge eclk);
      n_vec++;
      if (obs_w !== exp_w) begin n_bad++; $display("FAIL fetch k=%0d got %h want %h", k, obs_w, exp_w); end
      if (instr_valid) begin
        pulses++; p_last = ecnt; n_vec++;
        if (instr !== 8'hD5 || pc !== 12'h000) begin
          n_bad++; $display("FAIL fetch_first got %h pc=%h want D5 pc=000", instr, pc);
        end
      end
      if (k < 3 * P && (k % P) == 0) begin
        n_vec++;
        if (db !== 4'h0) begin n_bad++; $display("FAIL fetch_db k=%0d got %h want 0", k, db); end
      end
    end
    run = 1'b0;
    n_vec++;
    if (pulses !== 1) begin n_bad++; $display("FAIL fetch_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_stop();
    int pulses = 0;
    for (int j = 1; j <= CYC - 3 * P - 1 + 2 * P; j++) begin
      @(negedge eclk);
      n_vec++;
      if (obs_w !== exp_w) begin n_bad++; $display("FAIL stop j=%0d got %h want %h", j, obs_w, exp_w); end
      if (instr_valid) begin
        pulses++; n_vec++;
        if (instr !== 8'hD6 || pc !== 12'h001 || ecnt - p_last !== CYC) begin
          n_bad++;
          $display("FAIL stop_second got %h pc=%h gap=%0d want D6 pc=001 gap=%0d", instr, pc, ecnt - p_last, CYC);
        end
      end
    end
    n_vec++;
    if (busy !== 1'b0 || pc !== 12'h002 || pulses !== 1) begin
      n_bad++; $display("FAIL stop_idle got busy=%b pc=%h pulses=%0d want 0 002 1", busy, pc, pulses);
    end
  endtask

  task automatic test_restart();
    logic [3:0] wdb [3] = '{4'h2, 4'h0, 4'h0};
    int sync_n = 0, pulses = 0;
    run = 1'b1;
    for (int k = 0; k < CYC; k++) begin
      @(negedge eclk);
      n_vec++;
      if (obs_w !== exp_w) begin n_bad++; $display("FAIL restart k=%0d got %h want %h", k, obs_w, exp_w); end
      if (sync) sync_n++;
      if (k < 3 * P && (k % P) == 0) begin
        n_vec++;
        if (db !== wdb[k / P]) begin n_bad++; $display("FAIL restart_db k=%0d got %h want %h", k, db, wdb[k / P]); end
      end
      if (instr_valid) begin
        pulses++; n_vec++;
        if (instr !== 8'hF2) begin n_bad++; $display("FAIL restart_instr got %h want F2", instr); end
      end
    end
    n_vec++;
    if (sync_n !== P || pulses !== 1) begin
      n_bad++; $display("FAIL restart_sync got sync=%0d pulses=%0d want %0d 1", sync_n, pulses, P);
    end
  endtask

  task automatic test_jump();
`ifdef JUMP_EN
    logic [7:0]  wi [3] = '{8'hD5, 8'h40, 8'h06};
    logic [11:0] wp [3] = '{12'h000, 12'h007, 12'h008};
`else
    logic [7:0]  wi [3] = '{8'hD5, 8'hD6, 8'hF2};
    logic [11:0] wp [3] = '{12'h000, 12'h001, 12'h002};
`endif
    int pulses = 0;
    ereset = 1'b1;
    @(negedge eclk);
    ereset = 1'b0; run = 1'b1;
    for (int k = 0; k < 3 * CYC; k++) begin
      @(negedge eclk);
      n_vec++;
      if (obs_w !== exp_w) begin n_bad++; $display("FAIL jump k=%0d got %h want %h", k, obs_w, exp_w); end
      if (instr_valid && pulses < 3) begin
        n_vec++;
        if (instr !== wi[pulses] || pc !== wp[pulses]) begin
          n_bad++; $display("FAIL jump_fetch%0d got %h pc=%h want %h pc=%h", pulses, instr, pc, wi[pulses], wp[pulses]);
        end
        pulses++;
      end
      jmp_valid = (k == 10);
      jmp_addr  = (k == 10) ? 12'h007 : 12'h000;
    end
    n_vec++;
    if (pulses !== 3) begin n_bad++; $display("FAIL jump_pulses got %0d want 3", pulses); end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    ereset = 1'b1;
    @(negedge eclk);
    ereset = 1'b0; run = 1'b1;
    for (int k = 0; k <= 4 * P + 2; k++) @(negedge eclk);
    ereset = 1'b1;
    @(negedge eclk);
    ereset = 1'b0;
    n_vec++;
    if ({clk1, clk2, sync, cm_rom, db, busy, instr_valid, instr} !== 16'h0 || pc !== RST_PC) begin
      n_bad++; $display("FAIL reset_mid_zero got %h want 0 pc=%h", obs_w, RST_PC);
    end
    for (int j = 0; j < CYC + P; j++) begin
      @(negedge eclk);
      n_vec++;
      if (obs_w !== exp_w) begin n_bad++; $display("FAIL reset_mid j=%0d got %h want %h", j, obs_w, exp_w); end
      if (instr_valid) begin
        pulses++; n_vec++;
        if (instr !== 8'hD5 || pc !== RST_PC || j !== 5 * P) begin
          n_bad++; $display("FAIL reset_mid_fetch got %h pc=%h at %0d want D5 pc=%h at %0d", instr, pc, j, RST_PC, 5 * P);
        end
      end
    end
    n_vec++;
    if (pulses !== 1) begin n_bad++; $display("FAIL reset_mid_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      @(negedge eclk);
      n_vec++;
      if (obs_w !== exp_w) begin n_bad++; $display("FAIL random k=%0d got %h want %h", k, obs_w, exp_w); end
      run       = ($urandom_range(0, 9) != 0);
      jmp_valid = ($urandom_range(0, 19) == 0);
      jmp_addr  = 12'($urandom);
      ereset    = ($urandom_range(0, 499) == 0);
    end
    ereset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hD5; mem[1] = 8'hD6; mem[2] = 8'hF2; mem[7] = 8'h40; mem[8] = 8'h06;
    test_reset();
    test_wrap();
    test_fetch();
    test_stop();
    test_restart();
    test_jump();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
